// File: rtl/alu_seq_if.sv
// Operand/result bundle between the controller and the multi-cycle ALU.
interface alu_seq_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [2:0]   alu_cmd;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         sc_i;
    logic         busy;
    logic         done;
    logic [W-1:0] rslt;
    logic         sc_o;
    logic         pari;
    logic         zero;

    modport master (
        output start, alu_cmd, inA, inB, sc_i,
        input  busy, done, rslt, sc_o, pari, zero
    );

    modport slave (
        input  start, alu_cmd, inA, inB, sc_i,
        output busy, done, rslt, sc_o, pari, zero
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops complete on the capture edge, shifts
// take one edge per bit and MUL runs a W-step shift-add loop. Results and
// carry are held in registers until the next op completes.
module alu_seq #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(W)
) (
    input logic       clk,
    input logic       reset,
    alu_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_LSL  = 3'b001,
        OP_LSR  = 3'b010,
        OP_NAND = 3'b011,
        OP_SUB  = 3'b100,
        OP_MUL  = 3'b101,
        OP_XOR  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    localparam logic [SW:0] MUL_STEPS = (SW+1)'(W);
    localparam logic [SW:0] LAST_STEP = (SW+1)'(1);

    state_t         state_q;
    op_t            op_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   rslt_q;
    logic           sc_q;
    logic           cin_q;
    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] acc_q;
    logic [SW:0]    cnt_q;

    logic [SW-1:0]  shamt;
    logic [W:0]     sum_d;
    logic [W-1:0]   res_d;
    logic           cout_d;
    logic           iter_d;
    logic [SW:0]    steps_d;

    logic [2*W-1:0] step_acc_d;
    logic           step_out_d;
    logic [W:0]     mul_sum_d;

    assign shamt = bus.inB[SW-1:0];

    // Decode the incoming command: single-cycle result, or iteration count for shifts/MUL.
    always_comb begin
        sum_d   = '0;
        res_d   = '0;
        cout_d  = 1'b0;
        iter_d  = 1'b0;
        steps_d = '0;
        case (op_t'(bus.alu_cmd))
            OP_ADD: begin
                sum_d = {1'b0, bus.inA} + {1'b0, bus.inB} + {{W{1'b0}}, bus.sc_i};
                {cout_d, res_d} = sum_d;
            end
            OP_SUB: begin
                sum_d = {1'b0, bus.inA} - {1'b0, bus.inB} + {{W{1'b0}}, bus.sc_i};
                {cout_d, res_d} = sum_d;
            end
            OP_LSL, OP_LSR: begin
                if (shamt != '0) begin
                    iter_d  = 1'b1;
                    steps_d = {1'b0, shamt};
                end else begin
                    res_d = bus.inA;
                end
            end
            OP_NAND: res_d = ~(bus.inA & bus.inB);
            OP_MUL: begin
                iter_d  = 1'b1;
                steps_d = MUL_STEPS;
            end
            OP_XOR:  res_d = bus.inA ^ bus.inB;
            default: res_d = '0;
        endcase
    end

    // One iteration of the captured op; shifts use the low half of acc_q,
    // MUL keeps {partial product, remaining multiplier bits} across all of it.
    always_comb begin
        step_acc_d = acc_q;
        step_out_d = 1'b0;
        mul_sum_d  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        case (op_q)
            OP_LSL: begin
                step_acc_d[W-1:0] = {acc_q[W-2:0], cin_q};
                step_out_d        = acc_q[W-1];
            end
            OP_LSR: begin
                step_acc_d[W-1:0] = {cin_q, acc_q[W-1:1]};
                step_out_d        = acc_q[0];
            end
            OP_MUL:  step_acc_d = {mul_sum_d, acc_q[W-1:1]};
            default: step_acc_d = acc_q;
        endcase
    end

    // Control FSM with registered busy/done and result/carry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rslt_q  <= '0;
            sc_q    <= 1'b0;
            cin_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    acc_q <= step_acc_d;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rslt_q  <= step_acc_d[W-1:0];
                        sc_q    <= (op_q == OP_MUL) ? |step_acc_d[2*W-1:W] : step_out_d;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q    <= op_t'(bus.alu_cmd);
                        cin_q   <= bus.sc_i;
                        mcand_q <= bus.inA;
                        acc_q   <= (op_t'(bus.alu_cmd) == OP_MUL) ? {{W{1'b0}}, bus.inB}
                                                                  : {{W{1'b0}}, bus.inA};
                        cnt_q   <= steps_d;
                        if (iter_d) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            rslt_q  <= res_d;
                            sc_q    <= cout_d;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.rslt = rslt_q;
    assign bus.sc_o = sc_q;
    assign bus.pari = ^rslt_q;
    assign bus.zero = (rslt_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=8): directed ops push expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_alu_seq;

    typedef struct {
        string      nm;
        logic [7:0] r;
        logic       s;
        int         lat;
        int         cap;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    logic [7:0] last_r;

    alu_seq_if #(.W(8)) bus();

    alu_seq #(.W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_rslt"}, 32'(bus.rslt), 32'(e.r));
                chk({e.nm, "_sc_o"}, 32'(bus.sc_o), 32'(e.s));
                chk({e.nm, "_zero"}, 32'(bus.zero), 32'(e.r == 8'h00));
                chk({e.nm, "_pari"}, 32'(bus.pari), 32'(^e.r));
                chk({e.nm, "_lat"},  32'(cyc - e.cap + 1), 32'(e.lat));
                chk({e.nm, "_busy"}, 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input logic [7:0] er,
                         input logic es, input int el);
        exp_t e;
        @(negedge clk);
        bus.alu_cmd = cmd;
        bus.inA     = a;
        bus.inB     = b;
        bus.sc_i    = ci;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.nm  = nm;
        e.r   = er;
        e.s   = es;
        e.lat = el;
        e.cap = cyc;
        sb.push_back(e);
        last_r = er;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        last_r      = 8'h00;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.alu_cmd = 3'b000;
        bus.inA     = 8'h00;
        bus.inB     = 8'h00;
        bus.sc_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rslt", 32'(bus.rslt), 32'd0);
        chk("rst_sc_o", 32'(bus.sc_o), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_pari", 32'(bus.pari), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue("add_carry", 3'b000, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1); wait_idle();
        issue("add_wrap0", 3'b000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1); wait_idle();
        issue("sub_neg",   3'b100, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1); wait_idle();
        issue("sub_zero",  3'b100, 8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1); wait_idle();
        issue("lsl_3",     3'b001, 8'h81, 8'h03, 1'b1, 8'h0F, 1'b0, 4); wait_idle();
        issue("lsl_0",     3'b001, 8'h81, 8'h00, 1'b1, 8'h81, 1'b0, 1); wait_idle();
        issue("lsl_7",     3'b001, 8'h01, 8'h07, 1'b0, 8'h80, 1'b0, 8); wait_idle();
        issue("lsr_1",     3'b010, 8'h81, 8'h01, 1'b1, 8'hC0, 1'b1, 2); wait_idle();
        issue("lsr_7hi",   3'b010, 8'h80, 8'h0F, 1'b1, 8'hFF, 1'b0, 8); wait_idle();
        issue("nand",      3'b011, 8'hF0, 8'h3C, 1'b1, 8'hCF, 1'b0, 1); wait_idle();
        issue("xor",       3'b110, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1); wait_idle();
        issue("rsvd",      3'b111, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1); wait_idle();
        issue("mul_13_11", 3'b101, 8'd13,  8'd11,  1'b0, 8'h8F, 1'b0, 9); wait_idle();
        issue("mul_20_20", 3'b101, 8'd20,  8'd20,  1'b0, 8'h90, 1'b1, 9); wait_idle();
        issue("mul_ff_ff", 3'b101, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b1, 9); wait_idle();

        // Back-to-back: second start lands while the first op is in DONE.
        issue("b2b_add",   3'b000, 8'h10, 8'h22, 1'b0, 8'h32, 1'b0, 1);
        issue("b2b_xor",   3'b110, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1);
        wait_idle();

        // Start while busy is ignored and the previous result stays visible.
        issue("mul_ign", 3'b101, 8'd13, 8'd11, 1'b0, 8'h8F, 1'b0, 9);
        @(negedge clk);
        @(negedge clk);
        chk("ign_busy", 32'(bus.busy), 32'd1);
        chk("ign_hold", 32'(bus.rslt), 32'hFF);
        bus.alu_cmd = 3'b000;
        bus.inA     = 8'h01;
        bus.inB     = 8'h01;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign_busy2", 32'(bus.busy), 32'd1);
        chk("ign_hold2", 32'(bus.rslt), 32'hFF);
        wait_idle();

        // Reset during the fourth RUN cycle of a MUL discards the op.
        issue("mul_rst", 3'b101, 8'd20, 8'd20, 1'b0, 8'h90, 1'b1, 9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        sb.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_rslt", 32'(bus.rslt), 32'd0);
        chk("mrst_zero", 32'(bus.zero), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        issue("add_after_rst", 3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1); wait_idle();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
